// File: rtl/jtag_shifter_if.sv
// Command/response bus between a JTAG shifter engine and the controller that feeds it.
// The controller drives through the master modport; the shifter uses the slave modport.
interface jtag_shifter_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int LW = $clog2(DATA_WIDTH + 1);

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [LW-1:0]         cmd_len;
    logic [DATA_WIDTH-1:0] cmd_tms;
    logic [DATA_WIDTH-1:0] cmd_tdi;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_tdo;

    modport master (
        output cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_tdo
    );

    modport slave (
        input  cmd_valid, cmd_len, cmd_tms, cmd_tdi, rsp_ready,
        output cmd_ready, rsp_valid, rsp_tdo
    );
endinterface

// File: rtl/jtag_shifter.sv
// JTAG bit shifter: drives TMS/TDI bit by bit and captures TDO, one command per handshake.
// Optional legacy GPIO bit-bang path is enabled with the JTAG_SHIFTER_GPIO_BYPASS_EN macro.
module jtag_shifter #(
    parameter int DATA_WIDTH = 32,
    parameter int CLK_DIV    = 4
) (
    input  logic          clk,
    input  logic          resetn,
    jtag_shifter_if.slave bus,
    output logic          tck,
    output logic          tms,
    output logic          tdi,
    input  logic          tdo
`ifdef JTAG_SHIFTER_GPIO_BYPASS_EN
    ,
    input  logic          bypass,
    input  logic [3:0]    gpio_o,
    output logic [3:0]    gpio_i
`endif
);
    localparam int LW = $clog2(DATA_WIDTH + 1);
    localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                state_r;
    state_t                state_nxt_s;
    logic [DW-1:0]         div_r;
    logic [IW-1:0]         idx_r;
    logic [IW-1:0]         idx_inc_s;
    logic [LW-1:0]         len_r;
    logic [LW-1:0]         eff_len_s;
    logic [DATA_WIDTH-1:0] tms_sh_r;
    logic [DATA_WIDTH-1:0] tdi_sh_r;
    logic [DATA_WIDTH-1:0] rsp_tdo_r;
    logic                  tck_r;
    logic                  tms_r;
    logic                  tdi_r;
    logic                  rsp_valid_r;
    logic                  cmd_ready_r;
    logic                  cmd_ready_s;
    logic                  accept_s;
    logic                  div_last_s;
    logic                  last_bit_s;

    // Requested lengths beyond the register width are clipped to the width.
    function automatic logic [LW-1:0] eff_len(input logic [LW-1:0] len);
        if (len > LW'(DATA_WIDTH)) begin
            return LW'(DATA_WIDTH);
        end else begin
            return len;
        end
    endfunction

    assign eff_len_s  = eff_len(bus.cmd_len);
    assign accept_s   = bus.cmd_valid & cmd_ready_s;
    assign div_last_s = (div_r == DW'(CLK_DIV - 1));
    assign idx_inc_s  = idx_r + IW'(1'b1);
    assign last_bit_s = ((LW'(idx_r) + LW'(1'b1)) >= len_r);

    // Next-state logic for the shift sequencer.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (eff_len_s == {LW{1'b0}}) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = LOW;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOW: begin
                if (div_last_s) begin
                    state_nxt_s = HIGH;
                end else begin
                    state_nxt_s = LOW;
                end
            end
            HIGH: begin
                if (div_last_s) begin
                    if (last_bit_s) begin
                        state_nxt_s = DONE;
                    end else begin
                        state_nxt_s = LOW;
                    end
                end else begin
                    state_nxt_s = HIGH;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Datapath: divider, bit index, pin drivers, TDO capture and handshake flags.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            div_r       <= {DW{1'b0}};
            idx_r       <= {IW{1'b0}};
            len_r       <= {LW{1'b0}};
            tms_sh_r    <= {DATA_WIDTH{1'b0}};
            tdi_sh_r    <= {DATA_WIDTH{1'b0}};
            rsp_tdo_r   <= {DATA_WIDTH{1'b0}};
            tck_r       <= 1'b0;
            tms_r       <= 1'b1;
            tdi_r       <= 1'b0;
            rsp_valid_r <= 1'b0;
            cmd_ready_r <= 1'b0;
        end else begin
            rsp_valid_r <= (state_nxt_s == DONE);
            // Ready only reopens after a full cycle in IDLE, giving the one-cycle gap after a response.
            cmd_ready_r <= (state_r == IDLE) && (state_nxt_s == IDLE);
            if (state_nxt_s != state_r) begin
                div_r <= {DW{1'b0}};
            end else if ((state_r == LOW) || (state_r == HIGH)) begin
                div_r <= div_r + DW'(1'b1);
            end else begin
                div_r <= {DW{1'b0}};
            end
            if (accept_s) begin
                tms_sh_r  <= bus.cmd_tms;
                tdi_sh_r  <= bus.cmd_tdi;
                rsp_tdo_r <= {DATA_WIDTH{1'b0}};
                idx_r     <= {IW{1'b0}};
                len_r     <= eff_len_s;
                if (state_nxt_s == LOW) begin
                    tms_r <= bus.cmd_tms[0];
                    tdi_r <= bus.cmd_tdi[0];
                end else begin
                    tms_r <= tms_r;
                    tdi_r <= tdi_r;
                end
            end else if ((state_r == LOW) && (state_nxt_s == HIGH)) begin
                tck_r            <= 1'b1;
                rsp_tdo_r[idx_r] <= tdo;
            end else if ((state_r == HIGH) && (state_nxt_s == LOW)) begin
                tck_r <= 1'b0;
                idx_r <= idx_inc_s;
                tms_r <= tms_sh_r[idx_inc_s];
                tdi_r <= tdi_sh_r[idx_inc_s];
            end else if ((state_r == HIGH) && (state_nxt_s == DONE)) begin
                tck_r <= 1'b0;
            end else begin
                tck_r <= tck_r;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_tdo   = rsp_tdo_r;
    assign bus.cmd_ready = cmd_ready_s;

`ifdef JTAG_SHIFTER_GPIO_BYPASS_EN
    logic byp_act_s;
    logic unused_gpio_s;

    // Bit-bang only takes over the pins while the engine is parked in IDLE.
    assign byp_act_s     = bypass & (state_r == IDLE);
    assign unused_gpio_s = gpio_o[3];
    assign cmd_ready_s   = cmd_ready_r & ~byp_act_s;
    assign tdi           = byp_act_s ? gpio_o[0] : tdi_r;
    assign tms           = byp_act_s ? gpio_o[1] : tms_r;
    assign tck           = byp_act_s ? gpio_o[2] : tck_r;
    assign gpio_i        = byp_act_s ? {tdo, 3'b000} : 4'b0000;
`else
    assign cmd_ready_s   = cmd_ready_r;
    assign tdi           = tdi_r;
    assign tms           = tms_r;
    assign tck           = tck_r;
`endif

endmodule
